// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing one DDR write port among CH_NUM channel write buffers.
// Optional per-channel burst counters and a spurious-done flag when WR_ARB_STAT_EN is defined.
module ddr_wr_arbiter #(
    parameter int CH_NUM     = 4,
    parameter int CH_IDX_W   = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32
) (
    input  logic                           ddr_clk,
    input  logic                           ddr_rst,
    input  logic [CH_NUM-1:0]              ch_wreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]   ch_waddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]    ch_wr_len,
    input  logic [CH_NUM*8*DQ_WIDTH-1:0]   ch_wdata,
    output logic [CH_NUM-1:0]              ch_wrdy,
    output logic [CH_NUM-1:0]              ch_wdata_req,
    output logic [CH_NUM-1:0]              ch_wdone,
    output logic                           ddr_wreq,
    output logic [ADDR_WIDTH-1:0]          ddr_waddr,
    output logic [LEN_WIDTH-1:0]           ddr_wr_len,
    input  logic                           ddr_wrdy,
    input  logic                           ddr_wdata_req,
    input  logic                           ddr_wdone,
    output logic [8*DQ_WIDTH-1:0]          ddr_wdata,
    output logic [CH_IDX_W-1:0]            grant_idx,
`ifdef WR_ARB_STAT_EN
    output logic [CH_NUM*16-1:0]           burst_cnt,
    output logic                           err_spurious,
`endif
    output logic                           arb_busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_GAP} state_t;

    localparam logic [CH_IDX_W:0]   CH_NUM_W = (CH_IDX_W+1)'(CH_NUM);
    localparam logic [CH_IDX_W-1:0] LAST_IDX = CH_IDX_W'(CH_NUM - 1);

    state_t                  state_reg;
    logic [CH_IDX_W-1:0]     rr_ptr_reg;
    logic [CH_IDX_W-1:0]     grant_idx_reg;
    logic [CH_NUM-1:0]       grant_oh_reg;
    logic                    ddr_wreq_reg;
    logic [ADDR_WIDTH-1:0]   ddr_waddr_reg;
    logic [LEN_WIDTH-1:0]    ddr_wr_len_reg;

    logic [ADDR_WIDTH-1:0]   addr_arr [CH_NUM];
    logic [LEN_WIDTH-1:0]    len_arr  [CH_NUM];
    logic [8*DQ_WIDTH-1:0]   data_arr [CH_NUM];

    logic [CH_IDX_W-1:0]     win_idx;
    logic [CH_NUM-1:0]       win_oh;
    logic [CH_IDX_W:0]       cand;
    logic [CH_IDX_W-1:0]     rr_ptr_next;
    logic                    route_data;
    logic                    route_done;

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_slice
            assign addr_arr[gi] = ch_waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign len_arr[gi]  = ch_wr_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign data_arr[gi] = ch_wdata[gi*8*DQ_WIDTH +: 8*DQ_WIDTH];
        end
    endgenerate

    // Scan from the farthest offset down so the set bit closest to rr_ptr wins.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (CH_IDX_W+1)'(k);
            if (cand >= CH_NUM_W)
                cand = cand - CH_NUM_W;
            if (ch_wreq[cand[CH_IDX_W-1:0]])
                win_idx = cand[CH_IDX_W-1:0];
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    assign rr_ptr_next = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_reg      <= S_IDLE;
            rr_ptr_reg     <= '0;
            grant_idx_reg  <= '0;
            grant_oh_reg   <= '0;
            ddr_wreq_reg   <= 1'b0;
            ddr_waddr_reg  <= '0;
            ddr_wr_len_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|ch_wreq) begin
                        state_reg      <= S_REQ;
                        grant_idx_reg  <= win_idx;
                        grant_oh_reg   <= win_oh;
                        ddr_waddr_reg  <= addr_arr[win_idx];
                        ddr_wr_len_reg <= len_arr[win_idx];
                        ddr_wreq_reg   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ddr_wdata_req) begin
                        ddr_wreq_reg <= 1'b0;
                        state_reg    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (ddr_wdone) begin
                        state_reg    <= S_GAP;
                        rr_ptr_reg   <= rr_ptr_next;
                        grant_oh_reg <= '0;
                    end
                end
                S_GAP: begin
                    // The released channel's request drop is seen before re-arbitrating.
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign route_data = ddr_wdata_req & ((state_reg == S_REQ) | (state_reg == S_DATA));
    assign route_done = ddr_wdone & (state_reg == S_DATA);

    assign ch_wdata_req = {CH_NUM{route_data}} & grant_oh_reg;
    assign ch_wdone     = {CH_NUM{route_done}} & grant_oh_reg;
    assign ch_wrdy      = {CH_NUM{ddr_wrdy & (state_reg == S_IDLE)}};
    assign ddr_wdata    = data_arr[grant_idx_reg];
    assign ddr_wreq     = ddr_wreq_reg;
    assign ddr_waddr    = ddr_waddr_reg;
    assign ddr_wr_len   = ddr_wr_len_reg;
    assign grant_idx    = grant_idx_reg;
    assign arb_busy     = (state_reg != S_IDLE);

`ifdef WR_ARB_STAT_EN
    logic [15:0] burst_cnt_reg [CH_NUM];
    logic        err_spurious_reg;

    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_stat
            always_ff @(posedge ddr_clk) begin
                if (ddr_rst)
                    burst_cnt_reg[gi] <= '0;
                else if (ch_wdone[gi])
                    burst_cnt_reg[gi] <= burst_cnt_reg[gi] + 16'd1;
            end
            assign burst_cnt[gi*16 +: 16] = burst_cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst)
            err_spurious_reg <= 1'b0;
        else if (ddr_wdone && (state_reg != S_DATA))
            err_spurious_reg <= 1'b1;
    end

    assign err_spurious = err_spurious_reg;
`endif

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed testbench for ddr_wr_arbiter (4 channels); stat checks compile in with WR_ARB_STAT_EN.
module tb_ddr_wr_arbiter;

    localparam int CH_NUM     = 4;
    localparam int CH_IDX_W   = 2;
    localparam int ADDR_WIDTH = 27;
    localparam int LEN_WIDTH  = 16;
    localparam int DQ_WIDTH   = 32;
    localparam int DW         = 8*DQ_WIDTH;

    logic                         ddr_clk;
    logic                         ddr_rst;
    logic [CH_NUM-1:0]            ch_wreq;
    logic [CH_NUM*ADDR_WIDTH-1:0] ch_waddr;
    logic [CH_NUM*LEN_WIDTH-1:0]  ch_wr_len;
    logic [CH_NUM*DW-1:0]         ch_wdata;
    logic [CH_NUM-1:0]            ch_wrdy;
    logic [CH_NUM-1:0]            ch_wdata_req;
    logic [CH_NUM-1:0]            ch_wdone;
    logic                         ddr_wreq;
    logic [ADDR_WIDTH-1:0]        ddr_waddr;
    logic [LEN_WIDTH-1:0]         ddr_wr_len;
    logic                         ddr_wrdy;
    logic                         ddr_wdata_req;
    logic                         ddr_wdone;
    logic [DW-1:0]                ddr_wdata;
    logic [CH_IDX_W-1:0]          grant_idx;
    logic                         arb_busy;
`ifdef WR_ARB_STAT_EN
    logic [CH_NUM*16-1:0]         burst_cnt;
    logic                         err_spurious;
`endif

    int checks;
    int failures;

    ddr_wr_arbiter #(
        .CH_NUM(CH_NUM), .CH_IDX_W(CH_IDX_W), .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .DQ_WIDTH(DQ_WIDTH)
    ) dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .ch_wreq(ch_wreq), .ch_waddr(ch_waddr), .ch_wr_len(ch_wr_len), .ch_wdata(ch_wdata),
        .ch_wrdy(ch_wrdy), .ch_wdata_req(ch_wdata_req), .ch_wdone(ch_wdone),
        .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len),
        .ddr_wrdy(ddr_wrdy), .ddr_wdata_req(ddr_wdata_req), .ddr_wdone(ddr_wdone),
        .ddr_wdata(ddr_wdata), .grant_idx(grant_idx),
`ifdef WR_ARB_STAT_EN
        .burst_cnt(burst_cnt), .err_spurious(err_spurious),
`endif
        .arb_busy(arb_busy)
    );

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = ~ddr_clk;

    function automatic logic [DW-1:0] pat(input int i);
        return {8{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic wait_wreq(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (ddr_wreq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Drives the remainder of a granted burst without checking anything.
    task automatic finish_burst();
        ddr_wdata_req = 1'b1;
        tick();
        ddr_wdata_req = 1'b0;
        ch_wreq       = '0;
        ddr_wdone     = 1'b1;
        tick();
        ddr_wdone = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        ddr_rst = 1'b1;
        tick();
        tick();
        ddr_rst = 1'b0;
        #1;
        checks++;
        if ({ddr_wreq, arb_busy, grant_idx} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got wreq=%b busy=%b grant=%0d want 0 0 0", ddr_wreq, arb_busy, grant_idx);
        end
        checks++;
        if (ddr_waddr !== '0 || ddr_wr_len !== '0) begin
            failures++;
            $display("FAIL reset_addr got addr=%h len=%0d want 0 0", ddr_waddr, ddr_wr_len);
        end
        checks++;
        if (ch_wrdy !== 4'hF) begin
            failures++;
            $display("FAIL reset_wrdy got %b want 1111", ch_wrdy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int  n_req;
        bit  other_bad;
        bit  ok;
        ch_waddr[2*ADDR_WIDTH +: ADDR_WIDTH] = 27'h0001000;
        ch_wr_len[2*LEN_WIDTH +: LEN_WIDTH]  = 16'd60;
        ch_wreq = 4'b0100;
        tick();
        checks++;
        if (ddr_wreq !== 1'b1 || grant_idx !== 2'd2) begin
            failures++;
            $display("FAIL single_latency got wreq=%b grant=%0d want 1 2", ddr_wreq, grant_idx);
        end
        checks++;
        if (ddr_waddr !== 27'h0001000 || ddr_wr_len !== 16'd60) begin
            failures++;
            $display("FAIL single_latch got addr=%h len=%0d want 0001000 60", ddr_waddr, ddr_wr_len);
        end
        checks++;
        if (ch_wrdy !== 4'h0 || ddr_wdata !== pat(2)) begin
            failures++;
            $display("FAIL single_route got wrdy=%b data_ok=%b want 0000 1", ch_wrdy, ddr_wdata === pat(2));
        end
        n_req = 0;
        other_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ddr_wdata_req = 1'b1;
            #1;
            if (ch_wdata_req[2] === 1'b1) n_req++;
            if ((ch_wdata_req & 4'b1011) !== 4'b0000) other_bad = 1'b1;
            tick();
            if (i == 0) begin
                ch_wreq = '0;
                checks++;
                if (ddr_wreq !== 1'b0) begin
                    failures++;
                    $display("FAIL single_wreq_drop got %b want 0", ddr_wreq);
                end
            end
        end
        ddr_wdata_req = 1'b0;
        checks++;
        if (n_req != 60 || other_bad) begin
            failures++;
            $display("FAIL single_data_req got count=%0d other=%b want 60 0", n_req, other_bad);
        end
        ddr_wdone = 1'b1;
        #1;
        checks++;
        if (ch_wdone !== 4'b0100) begin
            failures++;
            $display("FAIL single_wdone got %b want 0100", ch_wdone);
        end
        tick();
        ddr_wdone = 1'b0;
        #1;
        checks++;
        if (arb_busy !== 1'b1 || ch_wdone !== 4'b0000) begin
            failures++;
            $display("FAIL single_gap got busy=%b wdone=%b want 1 0000", arb_busy, ch_wdone);
        end
        tick();
        checks++;
        if (arb_busy !== 1'b0 || grant_idx !== 2'd2) begin
            failures++;
            $display("FAIL single_hold got busy=%b grant=%0d want 0 2", arb_busy, grant_idx);
        end
        // rr_ptr should now be 3: channels 0 and 3 both asking must pick 3.
        ch_wreq = 4'b1001;
        wait_wreq(ok);
        checks++;
        if (!ok || grant_idx !== 2'd3) begin
            failures++;
            $display("FAIL single_rr_ptr got ok=%b grant=%0d want 1 3", ok, grant_idx);
        end
        finish_burst();
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp;
        ch_wreq = 4'hF;
        for (int b = 0; b < 8; b++) begin
            exp = b % 4;
            wait_wreq(ok);
            checks++;
            if (!ok || grant_idx !== 2'(exp) || ddr_wdata !== pat(exp)) begin
                failures++;
                $display("FAIL rr_grant burst=%0d got ok=%b grant=%0d want %0d", b, ok, grant_idx, exp);
            end
            ddr_wdata_req = 1'b1;
            #1;
            checks++;
            if (ch_wdata_req !== 4'(1 << exp)) begin
                failures++;
                $display("FAIL rr_data_req burst=%0d got %b want %b", b, ch_wdata_req, 4'(1 << exp));
            end
            tick();
            ddr_wdata_req = 1'b0;
            ddr_wdone     = 1'b1;
            tick();
            ddr_wdone = 1'b0;
            checks++;
            if (arb_busy !== 1'b1 || ddr_wreq !== 1'b0) begin
                failures++;
                $display("FAIL rr_gap burst=%0d got busy=%b wreq=%b want 1 0", b, arb_busy, ddr_wreq);
            end
            tick();
            if (b == 7) ch_wreq = '0;
        end
        $display("test_round_robin done");
    endtask

    task automatic test_withdraw();
        bit ok;
        ch_waddr[1*ADDR_WIDTH +: ADDR_WIDTH] = 27'h2ABCDEF;
        ch_wr_len[1*LEN_WIDTH +: LEN_WIDTH]  = 16'd7;
        ch_wreq = 4'b0010;
        wait_wreq(ok);
        ch_wreq = '0;
        tick();
        tick();
        tick();
        checks++;
        if (!ok || ddr_wreq !== 1'b1 || grant_idx !== 2'd1 || ddr_waddr !== 27'h2ABCDEF || ddr_wr_len !== 16'd7) begin
            failures++;
            $display("FAIL withdraw_hold got wreq=%b grant=%0d addr=%h len=%0d want 1 1 2abcdef 7", ddr_wreq, grant_idx, ddr_waddr, ddr_wr_len);
        end
        ddr_wdata_req = 1'b1;
        #1;
        checks++;
        if (ch_wdata_req !== 4'b0010) begin
            failures++;
            $display("FAIL withdraw_data_req got %b want 0010", ch_wdata_req);
        end
        tick();
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b1;
        #1;
        checks++;
        if (ch_wdone !== 4'b0010 || ddr_wreq !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_done got wdone=%b wreq=%b want 0010 0", ch_wdone, ddr_wreq);
        end
        tick();
        ddr_wdone = 1'b0;
        tick();
        $display("test_withdraw done");
    endtask

    task automatic test_spurious();
        bit ok;
        ddr_wdone     = 1'b1;
        ddr_wdata_req = 1'b1;
        #1;
        checks++;
        if (ch_wdone !== 4'b0000 || ch_wdata_req !== 4'b0000) begin
            failures++;
            $display("FAIL spur_idle got wdone=%b data_req=%b want 0000 0000", ch_wdone, ch_wdata_req);
        end
        tick();
        ddr_wdone     = 1'b0;
        ddr_wdata_req = 1'b0;
        checks++;
        if (arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle_state got busy=%b want 0", arb_busy);
        end
        ch_wreq = 4'b0001;
        wait_wreq(ok);
        ch_wreq   = '0;
        ddr_wdone = 1'b1;
        #1;
        checks++;
        if (!ok || ch_wdone !== 4'b0000) begin
            failures++;
            $display("FAIL spur_req got ok=%b wdone=%b want 1 0000", ok, ch_wdone);
        end
        tick();
        ddr_wdone = 1'b0;
        checks++;
        if (ddr_wreq !== 1'b1 || arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL spur_req_state got wreq=%b busy=%b want 1 1", ddr_wreq, arb_busy);
        end
        ddr_wdata_req = 1'b1;
        tick();
        ddr_wdone = 1'b1;
        #1;
        checks++;
        if (ch_wdata_req !== 4'b0001 || ch_wdone !== 4'b0001) begin
            failures++;
            $display("FAIL both_in_data got data_req=%b wdone=%b want 0001 0001", ch_wdata_req, ch_wdone);
        end
        tick();
        checks++;
        if (arb_busy !== 1'b1 || ch_wdata_req !== 4'b0000 || ch_wdone !== 4'b0000) begin
            failures++;
            $display("FAIL spur_gap got busy=%b data_req=%b wdone=%b want 1 0000 0000", arb_busy, ch_wdata_req, ch_wdone);
        end
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b0;
        tick();
`ifdef WR_ARB_STAT_EN
        checks++;
        if (err_spurious !== 1'b1) begin
            failures++;
            $display("FAIL stat_err_spurious got %b want 1", err_spurious);
        end
        // Bursts so far: ch0=3 ch1=3 ch2=3 ch3=3.
        checks++;
        if (burst_cnt !== {16'd3, 16'd3, 16'd3, 16'd3}) begin
            failures++;
            $display("FAIL stat_burst_cnt got %h want 0003000300030003", burst_cnt);
        end
`endif
        $display("test_spurious done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit done_seen;
        ch_wreq = 4'b0100;
        wait_wreq(ok);
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ddr_wdata_req = 1'b1;
            tick();
            ch_wreq = '0;
        end
        ddr_wdata_req = 1'b0;
        ddr_rst       = 1'b1;
        #1;
        tick();
        ddr_rst = 1'b0;
        ddr_wdone = 1'b1;
        #1;
        if (ch_wdone !== 4'b0000) done_seen = 1'b1;
        checks++;
        if (!ok || ddr_wreq !== 1'b0 || arb_busy !== 1'b0 || grant_idx !== 2'd0 || done_seen) begin
            failures++;
            $display("FAIL reset_mid got wreq=%b busy=%b grant=%0d wdone_seen=%b want 0 0 0 0", ddr_wreq, arb_busy, grant_idx, done_seen);
        end
        tick();
        ddr_wdone = 1'b0;
        // rr_ptr was 1 before reset; scanning from index 0 must pick channel 0.
        ch_wreq = 4'b1001;
        wait_wreq(ok);
        checks++;
        if (!ok || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_rescan got ok=%b grant=%0d want 1 0", ok, grant_idx);
        end
        finish_burst();
        ch_wreq = 4'b1000;
        wait_wreq(ok);
        checks++;
        if (!ok || grant_idx !== 2'd3) begin
            failures++;
            $display("FAIL reset_mid_ch3 got ok=%b grant=%0d want 1 3", ok, grant_idx);
        end
        finish_burst();
`ifdef WR_ARB_STAT_EN
        checks++;
        if (burst_cnt !== {16'd1, 16'd0, 16'd0, 16'd1} || err_spurious !== 1'b1) begin
            failures++;
            $display("FAIL stat_after_reset got cnt=%h err=%b want 0001000000000001 1", burst_cnt, err_spurious);
        end
`endif
        $display("test_reset_mid done");
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        ddr_rst       = 1'b1;
        ch_wreq       = '0;
        ch_waddr      = '0;
        ch_wr_len     = '0;
        ddr_wrdy      = 1'b1;
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            ch_waddr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(32'h100 * (i + 1));
            ch_wr_len[i*LEN_WIDTH +: LEN_WIDTH]  = LEN_WIDTH'(i + 4);
            ch_wdata[i*DW +: DW]                 = pat(i);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
